// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: RV32I opcodes, the EX/MEM scoreboard entry,
// the controller FSM states and the forwarding-select encoding.
package pipe_ctrl_pkg;

   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       reg_wr;
      logic       is_load;
   } stage_info_t;

   typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} hz_state_e;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_MEM = 2'b01,
      FWD_WB  = 2'b10
   } fwd_sel_e;

   // A stage produces rs when it holds a real register writer whose rd is not x0.
   function automatic logic hits(input stage_info_t s, input logic [4:0] rs);
      return s.valid & s.reg_wr & (s.rd != 5'd0) & (s.rd == rs);
   endfunction

   function automatic fwd_sel_e fwd_pick(input logic rd_en, input logic [4:0] rs,
                                         input stage_info_t ex, input stage_info_t mem);
      if (!rd_en)                       return FWD_RF;
      else if (hits(ex, rs) & ~ex.is_load) return FWD_MEM;
      else if (hits(mem, rs))            return FWD_WB;
      else                               return FWD_RF;
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_inst_field_decode.sv
// Extracts register fields and read/write usage from a raw RV32I instruction (purely combinational).
module inst_field_decode
   import pipe_ctrl_pkg::*;
(
   input  logic [31:0] i_inst,
   output logic [4:0]  o_rs1,
   output logic [4:0]  o_rs2,
   output logic [4:0]  o_rd,
   output logic        o_uses_rs1,
   output logic        o_uses_rs2,
   output logic        o_reg_wr,
   output logic        o_is_load
);

   logic w_unused_bits;

   assign o_rs1         = i_inst[19:15];
   assign o_rs2         = i_inst[24:20];
   assign o_rd          = i_inst[11:7];
   assign w_unused_bits = ^{i_inst[31:25], i_inst[14:12]};

   always_comb begin
      o_uses_rs1 = 1'b0;
      o_uses_rs2 = 1'b0;
      o_reg_wr   = 1'b0;
      o_is_load  = 1'b0;
      case (i_inst[6:0])
         OP:     begin o_uses_rs1 = 1'b1; o_uses_rs2 = 1'b1; o_reg_wr = 1'b1; end
         OP_IMM: begin o_uses_rs1 = 1'b1; o_reg_wr = 1'b1; end
         LOAD:   begin o_uses_rs1 = 1'b1; o_reg_wr = 1'b1; o_is_load = 1'b1; end
         STORE:  begin o_uses_rs1 = 1'b1; o_uses_rs2 = 1'b1; end
         BRANCH: begin o_uses_rs1 = 1'b1; o_uses_rs2 = 1'b1; end
         LUI, AUIPC, JAL: o_reg_wr = 1'b1;
         JALR:   begin o_uses_rs1 = 1'b1; o_reg_wr = 1'b1; end
         default: ;
      endcase
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard sequencer for the 5-stage RV32I pipeline: freezes on data-memory waits, flushes on
// redirects, inserts one-cycle load-use bubbles and registers the EX operand forwarding selects.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      i_inst_id,
   input  logic             i_valid_id,
   input  logic             i_br_taken,
   input  logic             i_mem_req,
   input  logic             i_mem_ready,
   output logic             o_stall_pc,
   output logic             o_stall_if_id,
   output logic             o_stall_id_ex,
   output logic             o_stall_ex_mem,
   output logic             o_flush_if_id,
   output logic             o_flush_id_ex,
   output logic [1:0]       o_fwd_sel_a,
   output logic [1:0]       o_fwd_sel_b,
   output logic [CNT_W-1:0] o_stall_cnt,
   output logic [CNT_W-1:0] o_flush_cnt,
   output hz_state_e        o_state
);

   logic [4:0]       w_rs1, w_rs2, w_rd;
   logic             w_uses_rs1, w_uses_rs2, w_reg_wr, w_is_load;
   logic             w_freeze, w_redirect, w_load_use, w_flush_ex, w_unused_mem;
   stage_info_t      w_id_info;
   hz_state_e        w_state_nxt;

   stage_info_t      r_ex_info, r_mem_info;
   hz_state_e        r_state;
   fwd_sel_e         r_fwd_a, r_fwd_b;
   logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

   inst_field_decode u_dec (
      .i_inst     (i_inst_id),
      .o_rs1      (w_rs1),
      .o_rs2      (w_rs2),
      .o_rd       (w_rd),
      .o_uses_rs1 (w_uses_rs1),
      .o_uses_rs2 (w_uses_rs2),
      .o_reg_wr   (w_reg_wr),
      .o_is_load  (w_is_load)
   );

   // Memory handshake: the access in MEM completes on a cycle with mem_req && mem_ready;
   // mem_req && !mem_ready freezes the whole pipeline in that same cycle.
   assign w_freeze     = i_mem_req & ~i_mem_ready;
   assign w_redirect   = i_br_taken & ~w_freeze;
   assign w_load_use   = r_ex_info.valid & r_ex_info.is_load & i_valid_id & ~w_freeze & ~w_redirect &
                         ((w_uses_rs1 & hits(r_ex_info, w_rs1)) | (w_uses_rs2 & hits(r_ex_info, w_rs2)));
   assign w_flush_ex   = w_redirect | w_load_use;
   assign w_id_info    = {i_valid_id, w_rd, w_reg_wr, w_is_load};
   assign w_unused_mem = r_mem_info.is_load;

   always_comb begin
      w_state_nxt    = r_state;
      o_stall_pc     = 1'b0;
      o_stall_if_id  = 1'b0;
      o_stall_id_ex  = 1'b0;
      o_stall_ex_mem = 1'b0;
      o_flush_if_id  = 1'b0;
      o_flush_id_ex  = 1'b0;
      case (r_state)
         RUN:      if (w_freeze)   w_state_nxt = MEM_WAIT;
         MEM_WAIT: if (i_mem_ready) w_state_nxt = RUN;
         default:  w_state_nxt = RUN;
      endcase
      // Outputs are forced low for the whole time reset is held, even with a pending freeze.
      if (rst_n) begin
         if (w_freeze) begin
            o_stall_pc     = 1'b1;
            o_stall_if_id  = 1'b1;
            o_stall_id_ex  = 1'b1;
            o_stall_ex_mem = 1'b1;
         end else if (w_redirect) begin
            o_flush_if_id  = 1'b1;
            o_flush_id_ex  = 1'b1;
         end else if (w_load_use) begin
            o_stall_pc     = 1'b1;
            o_stall_if_id  = 1'b1;
            o_flush_id_ex  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= RUN;
         r_ex_info   <= '0;
         r_mem_info  <= '0;
         r_fwd_a     <= FWD_RF;
         r_fwd_b     <= FWD_RF;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (!w_freeze) begin
            r_mem_info <= r_ex_info;
            r_ex_info  <= w_flush_ex ? stage_info_t'('0) : w_id_info;
            r_fwd_a    <= w_flush_ex ? FWD_RF :
                          fwd_pick(w_uses_rs1 & i_valid_id, w_rs1, r_ex_info, r_mem_info);
            r_fwd_b    <= w_flush_ex ? FWD_RF :
                          fwd_pick(w_uses_rs2 & i_valid_id, w_rs2, r_ex_info, r_mem_info);
         end
         if ((w_freeze | w_load_use) && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (w_redirect && (r_flush_cnt != '1))              r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
   end

   assign o_fwd_sel_a = r_fwd_a;
   assign o_fwd_sel_b = r_fwd_b;
   assign o_stall_cnt = r_stall_cnt;
   assign o_flush_cnt = r_flush_cnt;
   assign o_state     = r_state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scenarios followed by random traffic, checked against a producer-tracking pipeline model.
module tb_pipe_hazard_ctrl;

   localparam int CW  = 5;
   localparam int SAT = (1 << CW) - 1;

   localparam logic [6:0] T_OP = 7'b0110011, T_OPI = 7'b0010011, T_LD = 7'b0000011,
                          T_ST = 7'b0100011, T_BR = 7'b1100011, T_LUI = 7'b0110111,
                          T_AUI = 7'b0010111, T_JAL = 7'b1101111, T_JALR = 7'b1100111,
                          T_BAD = 7'b1111111;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [31:0]   inst;
   logic          valid, br, req, rdy;
   logic          stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id, flush_id_ex;
   logic [1:0]    fwd_a, fwd_b;
   logic [CW-1:0] stall_cnt, flush_cnt;
   logic          state;

   int total = 0;
   int bad   = 0;

   // Model: which register (or -1) the instruction in EX / MEM will write, and whether EX holds a load.
   int m_ex_rd, m_mem_rd, m_fa, m_fb, m_sc, m_fc;
   bit m_ex_ld, m_wait;

   pipe_hazard_ctrl #(.CNT_W(CW)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_inst_id      (inst),
      .i_valid_id     (valid),
      .i_br_taken     (br),
      .i_mem_req      (req),
      .i_mem_ready    (rdy),
      .o_stall_pc     (stall_pc),
      .o_stall_if_id  (stall_if_id),
      .o_stall_id_ex  (stall_id_ex),
      .o_stall_ex_mem (stall_ex_mem),
      .o_flush_if_id  (flush_if_id),
      .o_flush_id_ex  (flush_id_ex),
      .o_fwd_sel_a    (fwd_a),
      .o_fwd_sel_b    (fwd_b),
      .o_stall_cnt    (stall_cnt),
      .o_flush_cnt    (flush_cnt),
      .o_state        (state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] enc(input logic [6:0] opc, input int rd, input int rs1, input int rs2);
      logic [4:0] d, s1, s2;
      d  = rd[4:0];
      s1 = rs1[4:0];
      s2 = rs2[4:0];
      return {7'd0, s2, s1, 3'd0, d, opc};
   endfunction

   // Which registers an instruction reads and writes; -1 means "none", x0 is never a destination.
   function automatic void uses(input logic [31:0] ins, input bit v,
                                output int rs1, output int rs2, output int rd, output bit ld);
      int f1, f2, fd;
      f1 = int'(ins[19:15]);
      f2 = int'(ins[24:20]);
      fd = int'(ins[11:7]);
      rs1 = -1; rs2 = -1; rd = -1; ld = 1'b0;
      if (v) begin
         if (ins[6:0] inside {T_OP, T_OPI, T_LD, T_ST, T_BR, T_JALR}) rs1 = f1;
         if (ins[6:0] inside {T_OP, T_ST, T_BR})                       rs2 = f2;
         if (ins[6:0] inside {T_OP, T_OPI, T_LD, T_LUI, T_AUI, T_JAL, T_JALR} && fd != 0) rd = fd;
         ld = (ins[6:0] == T_LD);
      end
   endfunction

   function automatic int src(input int rs);
      if (rs < 0)                                  return 0;
      if (m_ex_rd >= 0 && rs == m_ex_rd && !m_ex_ld) return 1;
      if (m_mem_rd >= 0 && rs == m_mem_rd)          return 2;
      return 0;
   endfunction

   task automatic model_reset();
      m_ex_rd = -1; m_mem_rd = -1; m_ex_ld = 1'b0; m_wait = 1'b0;
      m_fa = 0; m_fb = 0; m_sc = 0; m_fc = 0;
   endtask

   // One pipeline cycle: drive at negedge, check everything, then advance the model past the posedge.
   task automatic cyc(input logic [31:0] ins, input bit v, input bit b, input bit rq, input bit ry);
      int rs1, rs2, rd;
      bit ld, fr, rdr, hz, fl;
      @(negedge clk);
      inst = ins; valid = v; br = b; req = rq; rdy = ry;
      #1;
      uses(ins, v, rs1, rs2, rd, ld);
      fr  = rq && !ry;
      rdr = b && !fr;
      hz  = !fr && !rdr && m_ex_ld && m_ex_rd >= 0 && (rs1 == m_ex_rd || rs2 == m_ex_rd);
      chk("stall_pc",     stall_pc,     fr || hz);
      chk("stall_if_id",  stall_if_id,  fr || hz);
      chk("stall_id_ex",  stall_id_ex,  fr);
      chk("stall_ex_mem", stall_ex_mem, fr);
      chk("flush_if_id",  flush_if_id,  rdr);
      chk("flush_id_ex",  flush_id_ex,  rdr || hz);
      chk("fwd_a",        fwd_a,        m_fa);
      chk("fwd_b",        fwd_b,        m_fb);
      chk("stall_cnt",    stall_cnt,    m_sc);
      chk("flush_cnt",    flush_cnt,    m_fc);
      chk("state",        state,        m_wait);
      m_wait = m_wait ? !ry : fr;
      if ((fr || hz) && m_sc < SAT) m_sc++;
      if (rdr && m_fc < SAT)        m_fc++;
      if (!fr) begin
         fl       = rdr || hz;
         m_fa     = fl ? 0 : src(rs1);
         m_fb     = fl ? 0 : src(rs2);
         m_mem_rd = m_ex_rd;
         m_ex_rd  = fl ? -1 : rd;
         m_ex_ld  = fl ? 1'b0 : ld;
      end
   endtask

   task automatic after_edge();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [6:0] opcs [10];
      logic [31:0] ri;
      bit rq;
      opcs = '{T_OP, T_OPI, T_LD, T_ST, T_BR, T_LUI, T_AUI, T_JAL, T_JALR, T_BAD};

      rst_n = 1'b0; inst = '0; valid = 1'b0; br = 1'b0; req = 1'b0; rdy = 1'b0;
      model_reset();
      #1;
      chk("rst_stall_pc", stall_pc, 0);
      chk("rst_flush_id_ex", flush_id_ex, 0);
      chk("rst_fwd_a", fwd_a, 0);
      chk("rst_stall_cnt", stall_cnt, 0);
      chk("rst_state", state, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // 1: ALU result forwarded from MEM stage
      cyc(enc(T_OP, 5, 1, 2), 1, 0, 0, 0);
      cyc(enc(T_OP, 6, 5, 3), 1, 0, 0, 0);
      chk("t1_no_stall", stall_pc, 0);
      after_edge();
      chk("t1_fwd_a", fwd_a, 1);
      chk("t1_fwd_b", fwd_b, 0);

      // 2: load-use bubble, then forwarding from WB
      cyc(enc(T_LD, 7, 1, 0), 1, 0, 0, 0);
      cyc(enc(T_OP, 8, 7, 7), 1, 0, 0, 0);
      chk("t2_stall_pc", stall_pc, 1);
      chk("t2_flush_id_ex", flush_id_ex, 1);
      cyc(enc(T_OP, 8, 7, 7), 1, 0, 0, 0);
      chk("t2_stall_clear", stall_pc, 0);
      after_edge();
      chk("t2_fwd_a", fwd_a, 2);
      chk("t2_fwd_b", fwd_b, 2);
      chk("t2_stall_cnt", stall_cnt, 1);

      // 3: taken branch flushes the add in ID
      cyc(enc(T_OP, 5, 0, 0), 1, 1, 0, 0);
      chk("t3_flush_if_id", flush_if_id, 1);
      chk("t3_flush_id_ex", flush_id_ex, 1);
      chk("t3_stall_pc", stall_pc, 0);
      after_edge();
      chk("t3_flush_cnt", flush_cnt, 1);
      cyc(enc(T_OP, 9, 5, 5), 1, 0, 0, 0);
      after_edge();
      chk("t3_x5_not_fwd", fwd_a, 0);

      // 4: store waits three cycles on data memory
      cyc(enc(T_ST, 0, 1, 2), 1, 0, 0, 0);
      cyc(enc(T_OP, 14, 1, 2), 1, 0, 1, 0);
      chk("t4_stall_ex_mem", stall_ex_mem, 1);
      after_edge();
      chk("t4_state_wait", state, 1);
      cyc(enc(T_OP, 14, 1, 2), 1, 0, 1, 0);
      cyc(enc(T_OP, 14, 1, 2), 1, 0, 1, 0);
      chk("t4_stall_id_ex", stall_id_ex, 1);
      cyc(enc(T_OP, 14, 1, 2), 1, 0, 1, 1);
      chk("t4_release", stall_pc, 0);
      after_edge();
      chk("t4_state_run", state, 0);
      chk("t4_stall_cnt", stall_cnt, 4);

      // 5: redirect beats load-use; redirect deferred across a memory wait
      cyc(enc(T_LD, 10, 2, 0), 1, 0, 0, 0);
      cyc(enc(T_OP, 11, 10, 0), 1, 1, 0, 0);
      chk("t5_no_stall", stall_pc, 0);
      chk("t5_flush", flush_id_ex, 1);
      cyc(enc(T_OP, 12, 1, 1), 1, 1, 1, 0);
      chk("t5_deferred", flush_if_id, 0);
      chk("t5_frozen", stall_pc, 1);
      cyc(enc(T_OP, 12, 1, 1), 1, 1, 1, 1);
      chk("t5_late_flush", flush_if_id, 1);
      after_edge();
      chk("t5_flush_cnt", flush_cnt, 3);
      chk("t5_stall_cnt", stall_cnt, 5);

      // 6: x0 producer never forwards; reset in the middle of a load-use stall
      cyc(enc(T_OPI, 0, 0, 1), 1, 0, 0, 0);
      cyc(enc(T_OP, 1, 0, 0), 1, 0, 0, 0);
      after_edge();
      chk("t6_fwd_a_x0", fwd_a, 0);
      chk("t6_fwd_b_x0", fwd_b, 0);
      cyc(enc(T_LD, 12, 1, 0), 1, 0, 0, 0);
      @(negedge clk);
      inst = enc(T_OP, 13, 12, 12); valid = 1'b1; br = 1'b0; req = 1'b0; rdy = 1'b0;
      #1;
      chk("t6_pre_stall", stall_pc, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_stall_pc", stall_pc, 0);
      chk("t6_rst_stall_if_id", stall_if_id, 0);
      chk("t6_rst_flush_id_ex", flush_id_ex, 0);
      chk("t6_rst_stall_cnt", stall_cnt, 0);
      chk("t6_rst_flush_cnt", flush_cnt, 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;

      // Random traffic over x0..x3; long enough for the stall counter to saturate.
      for (int n = 0; n < 600; n++) begin
         ri = enc(opcs[$urandom_range(0, 9)], $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3));
         rq = m_wait ? 1'b1 : ($urandom_range(0, 3) == 0);
         cyc(ri, $urandom_range(0, 7) != 0, $urandom_range(0, 6) == 0, rq, $urandom_range(0, 1) == 1);
      end
      after_edge();
      chk("sat_stall_cnt", stall_cnt, m_sc);
      chk("sat_flush_cnt", flush_cnt, m_fc);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
